// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that shares one register write bus among NUM_REQ requesters.
// Latency: request sampled in IDLE -> grant/reg_enable/bus_data driven the next cycle (one write per 3 cycles).
// Backpressure: losers keep their level request asserted; the grant pulse is the only accept indication.
module reg_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int DEST_W  = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*WIDTH-1:0]  req_data,
  input  logic [NUM_REQ*DEST_W-1:0] req_dest,
  output logic [NUM_REQ-1:0]        grant,
  output logic [WIDTH-1:0]          bus_data,
  output logic [(2**DEST_W)-1:0]    reg_enable,
  output logic                      busy
);

  localparam int NUM_REGS = 2**DEST_W;
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  // ptr: requester with first priority at the next arbitration.
  // winner: requester granted in the current write; drives the pointer update.
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    ptr_nxt;
  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    winner_nxt;

  logic [NUM_REQ-1:0]  grant_nxt;
  logic [WIDTH-1:0]    bus_data_nxt;
  logic [NUM_REGS-1:0] reg_enable_nxt;
  logic                busy_nxt;

  // Arbitration helpers
  logic [NUM_REQ-1:0]  req_ok;
  logic                any_req;
  logic [IDX_W-1:0]    pick;
  logic [WIDTH-1:0]    pick_data;
  logic [DEST_W-1:0]   pick_dest;
  int                  cand;

  // Only a clean logic 1 counts as a request; X/Z from an unset requester is ignored.
  always_comb begin
    req_ok = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ok[i] = (req[i] === 1'b1);
    end
  end

  // Scan from the priority pointer upward with wrap; first valid request wins.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!any_req && req_ok[cand]) begin
        any_req = 1'b1;
        pick    = IDX_W'(cand);
      end
    end
  end

  // Mux the winning requester's payload onto the capture path.
  always_comb begin
    pick_data = req_data[pick*WIDTH +: WIDTH];
    pick_dest = req_dest[pick*DEST_W +: DEST_W];
  end

  // Next-state and next-output logic; all outputs are registered from these values.
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    winner_nxt     = winner;
    grant_nxt      = '0;
    reg_enable_nxt = '0;
    bus_data_nxt   = bus_data;
    busy_nxt       = 1'b0;

    unique case (state)
      IDLE: begin
        if (any_req) begin
          // Payload is captured here; later changes by the requester are ignored.
          state_nxt      = WRITE;
          winner_nxt     = pick;
          grant_nxt      = NUM_REQ'(1) << pick;
          bus_data_nxt   = pick_data;
          reg_enable_nxt = NUM_REGS'(1) << pick_dest;
          busy_nxt       = 1'b1;
        end else begin
          // Idle bus is parked at zero.
          bus_data_nxt = '0;
        end
      end
      WRITE: begin
        // Single-cycle write; the winner drops to lowest priority.
        state_nxt = TURN;
        ptr_nxt   = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
      TURN: begin
        // Dead cycle lets the granted requester withdraw before re-arbitration.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      winner     <= '0;
      grant      <= '0;
      bus_data   <= '0;
      reg_enable <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      winner     <= winner_nxt;
      grant      <= grant_nxt;
      bus_data   <= bus_data_nxt;
      reg_enable <= reg_enable_nxt;
      busy       <= busy_nxt;
    end
  end

  // Structural invariants of the write pulse.
  a_grant_onehot : assert property (@(posedge clock) disable iff (reset) $onehot0(grant));
  a_enable_onehot : assert property (@(posedge clock) disable iff (reset) $onehot0(reg_enable));
  a_busy_state : assert property (@(posedge clock) disable iff (reset) busy == (state == WRITE));
  a_grant_in_write : assert property (@(posedge clock) disable iff (reset) (grant != '0) -> busy);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus randomized traffic.
// Latency: model predicts outputs for each clock edge; compared half a cycle later.
// Backpressure: requests are level signals held or dropped by the bench at negedges.
module tb_reg_write_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int WIDTH    = 8;
  localparam int DEST_W   = 3;
  localparam int NUM_REGS = 2**DEST_W;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*WIDTH-1:0]  req_data;
  logic [NUM_REQ*DEST_W-1:0] req_dest;
  logic [NUM_REQ-1:0]        grant;
  logic [WIDTH-1:0]          bus_data;
  logic [NUM_REGS-1:0]       reg_enable;
  logic                      busy;

  int checks = 0;
  int errors = 0;

  // Reference model: a pointer, a cooldown count of cycles before the next
  // arbitration may happen, and the predicted outputs after each edge.
  int                  m_ptr;
  int                  m_gap;
  logic [NUM_REQ-1:0]  m_grant;
  logic [NUM_REGS-1:0] m_en;
  logic [WIDTH-1:0]    m_data;
  logic                m_busy;

  reg_write_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .DEST_W  (DEST_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .req_dest   (req_dest),
    .grant      (grant),
    .bus_data   (bus_data),
    .reg_enable (reg_enable),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Advance one clock edge, update the model from the inputs seen at that edge,
  // and return at the following negedge where outputs are stable.
  task automatic step();
    int w;
    @(posedge clock);
    if (reset === 1'b1) begin
      m_ptr = 0; m_gap = 0;
      m_grant = '0; m_en = '0; m_data = '0; m_busy = 1'b0;
    end else begin
      m_grant = '0; m_en = '0; m_busy = 1'b0;
      if (m_gap > 0) begin
        m_gap = m_gap - 1;
      end else begin
        w = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (w < 0 && req[(m_ptr + k) % NUM_REQ] === 1'b1) w = (m_ptr + k) % NUM_REQ;
        end
        if (w >= 0) begin
          m_grant[w] = 1'b1;
          m_data = req_data[w*WIDTH +: WIDTH];
          m_en[req_dest[w*DEST_W +: DEST_W]] = 1'b1;
          m_busy = 1'b1;
          m_ptr = (w + 1) % NUM_REQ;
          m_gap = 2;
        end else begin
          m_data = '0;
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset = 1'b1; req = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; req_data = '0; req_dest = '0;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if ({grant, reg_enable, bus_data, busy} !== '0) begin
        errors++;
        $display("FAIL reset_hold c%0d: got grant=%b en=%h data=%h busy=%b, want all zero", c, grant, reg_enable, bus_data, busy);
      end
    end
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if ({grant, reg_enable, bus_data, busy} !== '0) begin
        errors++;
        $display("FAIL reset_idle c%0d: got grant=%b en=%h data=%h busy=%b, want all zero", c, grant, reg_enable, bus_data, busy);
      end
    end
  endtask

  task automatic test_single();
    logic [NUM_REQ+NUM_REGS+WIDTH:0] exp_v [4];
    exp_v[0] = {4'b0001, 8'h08, 8'hA5, 1'b1};
    exp_v[1] = {4'b0000, 8'h00, 8'hA5, 1'b0};
    exp_v[2] = {4'b0000, 8'h00, 8'hA5, 1'b0};
    exp_v[3] = {4'b0000, 8'h00, 8'h00, 1'b0};
    apply_reset();
    req_data[0 +: WIDTH] = 8'hA5; req_dest[0 +: DEST_W] = 3'd3; req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      step();
      req = '0;
      checks++;
      if ({grant, reg_enable, bus_data, busy} !== exp_v[c]) begin
        errors++;
        $display("FAIL single c%0d: got {grant,en,data,busy}=%h, want %h", c, {grant, reg_enable, bus_data, busy}, exp_v[c]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0]  eg;
    logic [NUM_REGS-1:0] ee;
    logic [WIDTH-1:0]    ed;
    int w;
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[i*WIDTH +: WIDTH]   = WIDTH'(8'h10 + i);
      req_dest[i*DEST_W +: DEST_W] = DEST_W'(i);
    end
    req = 4'b1111;
    ed = '0;
    for (int c = 0; c < 15; c++) begin
      step();
      eg = '0; ee = '0;
      if (c % 3 == 0) begin
        w = (c / 3) % NUM_REQ;
        eg[w] = 1'b1; ee[w] = 1'b1; ed = WIDTH'(8'h10 + w);
      end
      checks++;
      if ({grant, reg_enable, bus_data, busy} !== {eg, ee, ed, (c % 3 == 0)}) begin
        errors++;
        $display("FAIL round_robin c%0d: got grant=%b en=%h data=%h busy=%b, want grant=%b en=%h data=%h busy=%b",
                 c, grant, reg_enable, bus_data, busy, eg, ee, ed, (c % 3 == 0));
      end
    end
    req = '0;
  endtask

  task automatic test_fairness();
    int order [3] = '{0, 2, 0};
    logic [NUM_REQ-1:0] eg;
    apply_reset();
    req_data[0 +: WIDTH] = 8'h11; req_data[2*WIDTH +: WIDTH] = 8'h22;
    req_dest[0 +: DEST_W] = 3'd6; req_dest[2*DEST_W +: DEST_W] = 3'd7;
    req = 4'b0101;
    for (int c = 0; c < 9; c++) begin
      step();
      eg = '0;
      if (c % 3 == 0) eg[order[c/3]] = 1'b1;
      checks++;
      if (grant !== eg) begin
        errors++;
        $display("FAIL fairness c%0d: got grant=%b, want %b", c, grant, eg);
      end
    end
    req = '0;
  endtask

  task automatic test_sample_hold();
    apply_reset();
    req_data[0 +: WIDTH] = 8'h3C; req_dest[0 +: DEST_W] = 3'd5; req = 4'b0001;
    step();
    checks++;
    if ({grant, reg_enable, bus_data} !== {4'b0001, 8'h20, 8'h3C}) begin
      errors++;
      $display("FAIL sample_write: got grant=%b en=%h data=%h, want 0001 20 3c", grant, reg_enable, bus_data);
    end
    req_data[0 +: WIDTH] = 8'hFF;
    step();
    checks++;
    if (bus_data !== 8'h3C) begin
      errors++;
      $display("FAIL sample_hold: got data=%h, want 3c", bus_data);
    end
    req = '0;
    step();
    checks++;
    if ({grant, reg_enable, bus_data, busy} !== {4'b0000, 8'h00, 8'h3C, 1'b0}) begin
      errors++;
      $display("FAIL sample_turn: got grant=%b en=%h data=%h busy=%b, want 0 0 3c 0", grant, reg_enable, bus_data, busy);
    end
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    req_data[0 +: WIDTH] = 8'h77; req_dest[0 +: DEST_W] = 3'd1;
    req_data[1*WIDTH +: WIDTH] = 8'h88; req_dest[1*DEST_W +: DEST_W] = 3'd2;
    req = 4'b0001;
    step();
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: got grant=%b busy=%b, want 0001 1", grant, busy);
    end
    reset = 1'b1; req = '0;
    step();
    checks++;
    if ({grant, reg_enable, bus_data, busy} !== '0) begin
      errors++;
      $display("FAIL midrst_clear: got grant=%b en=%h data=%h busy=%b, want all zero", grant, reg_enable, bus_data, busy);
    end
    reset = 1'b0; req = 4'b0011;
    step();
    checks++;
    if ({grant, reg_enable, bus_data} !== {4'b0001, 8'h02, 8'h77}) begin
      errors++;
      $display("FAIL midrst_ptr: got grant=%b en=%h data=%h, want 0001 02 77", grant, reg_enable, bus_data);
    end
    req = '0;
    step(); step();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) req = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      req_data = NUM_REQ*WIDTH'($urandom);
      req_dest = NUM_REQ*DEST_W'($urandom);
      reset = ($urandom_range(0, 63) == 0);
      step();
      checks++;
      if ({grant, reg_enable, bus_data, busy} !== {m_grant, m_en, m_data, m_busy}) begin
        errors++;
        $display("FAIL random c%0d: got grant=%b en=%h data=%h busy=%b, want grant=%b en=%h data=%h busy=%b",
                 c, grant, reg_enable, bus_data, busy, m_grant, m_en, m_data, m_busy);
      end
    end
    reset = 1'b0; req = '0;
  endtask

  initial begin
    reset = 1'b1; req = '0; req_data = '0; req_dest = '0;
    m_ptr = 0; m_gap = 0; m_grant = '0; m_en = '0; m_data = '0; m_busy = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_sample_hold();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
